blob_bbox: RTL and testbench

Downstream consumer of the pixel-coordinate counter. Takes the per-pixel `x`/`y` stream plus a per-pixel colour-match flag and accumulates a bounding box of matching pixels over one frame. A run-length filter suppresses isolated noise pixels. At end of frame it publishes the box, the qualified pixel count and a found flag with a one-cycle strobe, for the rover's target-tracking logic.

---
 rtl/blob_bbox_if.sv | 25 ++
 rtl/blob_bbox.sv | 142 ++++++++++++++
 tb/tb_blob_bbox.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/blob_bbox_if.sv
// Pixel stream into the bounding-box accumulator and the per-frame result back out.
`timescale 1ns/1ps
interface blob_bbox_if;
   logic [15:0] x;
   logic [15:0] y;
   logic        in_valid;
   logic        hit;
   logic        box_valid;
   logic        found;
   logic [15:0] x_min;
   logic [15:0] x_max;
   logic [15:0] y_min;
   logic [15:0] y_max;
   logic [31:0] pix_count;

   modport master (
      output x, y, in_valid, hit,
      input  box_valid, found, x_min, x_max, y_min, y_max, pix_count
   );

   modport slave (
      input  x, y, in_valid, hit,
      output box_valid, found, x_min, x_max, y_min, y_max, pix_count
   );
endinterface

// File: rtl/blob_bbox.sv
// Bounding box, qualified pixel count and found flag of colour-matching pixels over one frame,
// with a run-length filter that drops short in-line runs of hits.
`timescale 1ns/1ps
module blob_bbox #(
   parameter int unsigned LINE_WIDTH = 640,
   parameter int unsigned ROW_NUMBER = 480,
   parameter int unsigned RUN_LEN    = 2,
   parameter int unsigned MIN_PIXELS = 16
) (
   input logic        clk,
   input logic        rst,
   blob_bbox_if.slave bus
);
   localparam logic [15:0] XLAST    = 16'(LINE_WIDTH - 1);
   localparam logic [15:0] YLAST    = 16'(ROW_NUMBER - 1);
   localparam logic [3:0]  RUN_MAX  = 4'(RUN_LEN);
   localparam logic [3:0]  RUN_PRE  = 4'(RUN_LEN - 1);
   localparam logic [15:0] RUN_BACK = 16'(RUN_LEN - 1);

   typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

   state_t      state_q;
   logic [15:0] xmin_q, xmax_q, ymin_q, ymax_q;
   logic [15:0] xmin_b, xmax_b, ymin_b, ymax_b;
   logic [15:0] xmin_d, xmax_d, ymin_d, ymax_d;
   logic [31:0] cnt_q, cnt_b, cnt_d;
   logic [3:0]  run_q, run_b, run_d;
   logic [31:0] inc;
   logic [32:0] sum;
   logic [15:0] lo;
   logic        upd;
   logic        in_range, frame_start, last_pix, proc, found_d;

   logic        box_valid_q, found_q;
   logic [15:0] x_min_q, x_max_q, y_min_q, y_max_q;
   logic [31:0] pix_count_q;

   always_comb begin
      in_range    = bus.in_valid && (32'(bus.x) < LINE_WIDTH) && (32'(bus.y) < ROW_NUMBER);
      frame_start = in_range && (bus.x == '0) && (bus.y == '0);
      last_pix    = in_range && (bus.x == XLAST) && (bus.y == YLAST);
      proc        = in_range && ((state_q == ACCUM) || frame_start);

      // A frame start processes its own pixel against freshly cleared accumulators.
      if (frame_start) begin
         xmin_b = XLAST;
         xmax_b = '0;
         ymin_b = YLAST;
         ymax_b = '0;
         cnt_b  = '0;
      end else begin
         xmin_b = xmin_q;
         xmax_b = xmax_q;
         ymin_b = ymin_q;
         ymax_b = ymax_q;
         cnt_b  = cnt_q;
      end
      run_b = (bus.x == '0) ? '0 : run_q;

      inc   = '0;
      lo    = bus.x;
      upd   = 1'b0;
      run_d = '0;
      if (bus.hit) begin
         run_d = (run_b == RUN_MAX) ? run_b : run_b + 4'd1;
         if (run_b == RUN_PRE) begin
            inc = 32'(RUN_LEN);
            lo  = bus.x - RUN_BACK;
            upd = 1'b1;
         end else if (run_b == RUN_MAX) begin
            inc = 32'd1;
            upd = 1'b1;
         end
      end

      sum   = {1'b0, cnt_b} + {1'b0, inc};
      cnt_d = sum[32] ? '1 : sum[31:0];

      xmin_d = xmin_b;
      xmax_d = xmax_b;
      ymin_d = ymin_b;
      ymax_d = ymax_b;
      if (upd) begin
         if (lo < xmin_b)    xmin_d = lo;
         if (bus.x > xmax_b) xmax_d = bus.x;
         if (bus.y < ymin_b) ymin_d = bus.y;
         if (bus.y > ymax_b) ymax_d = bus.y;
      end
      found_d = (cnt_d >= 32'(MIN_PIXELS));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         xmin_q      <= XLAST;
         xmax_q      <= '0;
         ymin_q      <= YLAST;
         ymax_q      <= '0;
         cnt_q       <= '0;
         run_q       <= '0;
         box_valid_q <= 1'b0;
         found_q     <= 1'b0;
         x_min_q     <= '0;
         x_max_q     <= '0;
         y_min_q     <= '0;
         y_max_q     <= '0;
         pix_count_q <= '0;
      end else begin
         box_valid_q <= 1'b0;
         if (proc) begin
            xmin_q <= xmin_d;
            xmax_q <= xmax_d;
            ymin_q <= ymin_d;
            ymax_q <= ymax_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
         end
         if (proc && last_pix) begin
            state_q     <= REPORT;
            box_valid_q <= 1'b1;
            found_q     <= found_d;
            pix_count_q <= cnt_d;
            x_min_q     <= found_d ? xmin_d : '0;
            x_max_q     <= found_d ? xmax_d : '0;
            y_min_q     <= found_d ? ymin_d : '0;
            y_max_q     <= found_d ? ymax_d : '0;
         end else if (proc) begin
            state_q <= ACCUM;
         end else if (state_q == REPORT) begin
            state_q <= IDLE;
         end
      end
   end

   assign bus.box_valid = box_valid_q;
   assign bus.found     = found_q;
   assign bus.x_min     = x_min_q;
   assign bus.x_max     = x_max_q;
   assign bus.y_min     = y_min_q;
   assign bus.y_max     = y_max_q;
   assign bus.pix_count = pix_count_q;
endmodule

// File: tb/tb_blob_bbox.sv
// Directed frames on a 10x3 raster into two instances (MIN_PIXELS 2 and 4); a queue holds per-frame expectations.
`timescale 1ns/1ps
module tb_blob_bbox;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   blob_bbox_if bus2();
   blob_bbox_if bus4();

   blob_bbox #(.LINE_WIDTH(10), .ROW_NUMBER(3), .RUN_LEN(2), .MIN_PIXELS(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2.slave));
   blob_bbox #(.LINE_WIDTH(10), .ROW_NUMBER(3), .RUN_LEN(2), .MIN_PIXELS(4)) dut4 (
      .clk(clk), .rst(rst), .bus(bus4.slave));

   typedef struct {
      logic [31:0] cnt;
      logic [15:0] x0, x1, y0, y1;
   } exp_t;

   exp_t        q2[$], q4[$];
   exp_t        e2, e4;
   int unsigned n_pass = 0, n_fail = 0, n_total = 0;
   int unsigned strobes2 = 0, strobes4 = 0, frames = 0;
   logic        prev2 = 1'b0, prev4 = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cmp_outs(input string sfx, input logic f, input logic [15:0] a, b, c, d,
                           input logic [31:0] n, input logic ef, input logic [15:0] ea, eb, ec, ed,
                           input logic [31:0] en);
      chk({"found", sfx}, 32'(f), 32'(ef));
      chk({"x_min", sfx}, 32'(a), 32'(ea));
      chk({"x_max", sfx}, 32'(b), 32'(eb));
      chk({"y_min", sfx}, 32'(c), 32'(ec));
      chk({"y_max", sfx}, 32'(d), 32'(ed));
      chk({"pix_count", sfx}, n, en);
   endtask

   task automatic check_report(input string sfx, input exp_t e, input int unsigned minp, input logic f,
                               input logic [15:0] a, b, c, d, input logic [31:0] n);
      logic ef;
      ef = (e.cnt >= minp);
      cmp_outs(sfx, f, a, b, c, d, n, ef, ef ? e.x0 : 16'd0, ef ? e.x1 : 16'd0,
               ef ? e.y0 : 16'd0, ef ? e.y1 : 16'd0, e.cnt);
   endtask

   always @(negedge clk) begin
      if (bus2.box_valid === 1'b1) begin
         strobes2++;
         chk("strobe_len_2", 32'(prev2), 32'd0);
         chk("strobe_expected_2", 32'(q2.size() != 0), 32'd1);
         if (q2.size() != 0) begin
            e2 = q2.pop_front();
            check_report("_2", e2, 2, bus2.found, bus2.x_min, bus2.x_max, bus2.y_min, bus2.y_max,
                         bus2.pix_count);
         end
      end
      prev2 = bus2.box_valid;
   end

   always @(negedge clk) begin
      if (bus4.box_valid === 1'b1) begin
         strobes4++;
         chk("strobe_len_4", 32'(prev4), 32'd0);
         chk("strobe_expected_4", 32'(q4.size() != 0), 32'd1);
         if (q4.size() != 0) begin
            e4 = q4.pop_front();
            check_report("_4", e4, 4, bus4.found, bus4.x_min, bus4.x_max, bus4.y_min, bus4.y_max,
                         bus4.pix_count);
         end
      end
      prev4 = bus4.box_valid;
   end

   task automatic beat(input int xx, input int yy, input logic h, input logic v);
      @(posedge clk);
      #1;
      bus2.x = 16'(xx); bus2.y = 16'(yy); bus2.hit = h; bus2.in_valid = v;
      bus4.x = 16'(xx); bus4.y = 16'(yy); bus4.hit = h; bus4.in_valid = v;
   endtask

   function automatic logic [29:0] px(input int xx, input int yy);
      logic [29:0] one;
      one = 30'd1;
      return one << (yy * 10 + xx);
   endfunction

   // Stall beats carry x=0,y=0 with hit set so an unstalled design would misread them as a frame start.
   task automatic frame(input logic [29:0] mask, input int stall_after, input logic [31:0] c,
                        input logic [15:0] x0, x1, y0, y1);
      exp_t e;
      e.cnt = c; e.x0 = x0; e.x1 = x1; e.y0 = y0; e.y1 = y1;
      q2.push_back(e);
      q4.push_back(e);
      frames++;
      for (int yy = 0; yy < 3; yy++) begin
         for (int xx = 0; xx < 10; xx++) begin
            beat(xx, yy, mask[yy * 10 + xx], 1'b1);
            if (yy * 10 + xx == stall_after) repeat (3) beat(0, 0, 1'b1, 1'b0);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      bus2.x = '0; bus2.y = '0; bus2.hit = 1'b0; bus2.in_valid = 1'b0;
      bus4.x = '0; bus4.y = '0; bus4.hit = 1'b0; bus4.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("box_valid_rst_2", 32'(bus2.box_valid), 32'd0);
      chk("box_valid_rst_4", 32'(bus4.box_valid), 32'd0);
      cmp_outs("_rst_2", bus2.found, bus2.x_min, bus2.x_max, bus2.y_min, bus2.y_max, bus2.pix_count,
               1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
      cmp_outs("_rst_4", bus4.found, bus4.x_min, bus4.x_max, bus4.y_min, bus4.y_max, bus4.pix_count,
               1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
      rst = 1'b1;

      // Beats before any frame start, including the last-pixel position, must be ignored.
      beat(5, 1, 1'b1, 1'b1);
      beat(6, 1, 1'b1, 1'b1);
      beat(9, 2, 1'b1, 1'b1);

      frame(px(3, 1) | px(4, 1) | px(5, 1), -1, 32'd3, 16'd3, 16'd5, 16'd1, 16'd1);
      frame(px(2, 0) | px(7, 2), -1, 32'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      frame(px(0, 0) | px(1, 0) | px(2, 0), -1, 32'd3, 16'd0, 16'd2, 16'd0, 16'd0);
      frame(px(6, 0) | px(7, 0) | px(9, 0) | px(0, 1) | px(1, 2) | px(2, 2), -1,
            32'd4, 16'd1, 16'd7, 16'd0, 16'd2);
      frame(px(4, 1) | px(5, 1), 14, 32'd2, 16'd4, 16'd5, 16'd1, 16'd1);
      frame(px(8, 2) | px(9, 2), -1, 32'd2, 16'd8, 16'd9, 16'd2, 16'd2);
      frame(px(0, 0) | px(1, 0), -1, 32'd2, 16'd0, 16'd1, 16'd0, 16'd0);

      for (int i = 0; i < 15; i++) beat(i % 10, i / 10, (i >= 12), 1'b1);
      beat(5, 1, 1'b1, 1'b1);
      rst = 1'b0;
      #1;
      chk("box_valid_mid_2", 32'(bus2.box_valid), 32'd0);
      cmp_outs("_mid_2", bus2.found, bus2.x_min, bus2.x_max, bus2.y_min, bus2.y_max, bus2.pix_count,
               1'b0, 16'd0, 16'd0, 16'd0, 16'd0, 32'd0);
      chk("pix_count_mid_4", bus4.pix_count, 32'd0);
      beat(6, 1, 1'b1, 1'b1);
      beat(7, 1, 1'b1, 1'b1);
      rst = 1'b1;
      beat(8, 1, 1'b1, 1'b1);
      beat(9, 1, 1'b0, 1'b1);
      for (int xx = 0; xx < 10; xx++) beat(xx, 2, 1'b0, 1'b1);

      frame(px(4, 0) | px(5, 0) | px(6, 0), -1, 32'd3, 16'd4, 16'd6, 16'd0, 16'd0);

      repeat (5) beat(0, 0, 1'b0, 1'b0);
      chk("pending_2", q2.size(), 32'd0);
      chk("pending_4", q4.size(), 32'd0);
      chk("strobes_2", strobes2, frames);
      chk("strobes_4", strobes4, frames);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
